// File: rtl/serial_word_receiver.sv
// Bit-serial to parallel word receiver with a one-cycle valid pulse per completed frame.
// Define SER_RX_PARITY_EN to append an even-parity bit to each frame (enables PAR state and perr).
`timescale 1ns/1ps
module serial_word_receiver #(
  parameter int WIDTH     = 32,
  parameter int LSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         din,
  output logic [WIDTH-1:0]             word,
  output logic                         valid,
  output logic                         busy,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         perr
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

`ifdef SER_RX_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;
`else
  typedef enum logic {IDLE, RECV} state_t;
`endif

  state_t state, state_next;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_src;
  logic             capture;
  logic             last_bit;
  logic             load_word;
`ifdef SER_RX_PARITY_EN
  logic             par_ok;
  logic             par_fail;
  logic             perr_q;
`endif

  // After WIDTH shifts the first bit has travelled to the far end of the register.
  assign shifted = (LSB_FIRST != 0) ? {din, shift_reg[WIDTH-1:1]}
                                    : {shift_reg[WIDTH-2:0], din};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RECV;
`ifdef SER_RX_PARITY_EN
      RECV: if (bit_count == LAST) state_next = PAR;
      PAR:  state_next = IDLE;
`else
      RECV: if (bit_count == LAST) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    capture  = (state == RECV) || ((state == IDLE) && start);
    last_bit = (state == RECV) && (bit_count == LAST);
`ifdef SER_RX_PARITY_EN
    par_ok    = ~(^shift_reg ^ din);
    load_word = (state == PAR) && par_ok;
    par_fail  = (state == PAR) && !par_ok;
    word_src  = shift_reg;
`else
    load_word = last_bit;
    word_src  = shifted;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      word      <= '0;
      valid     <= 1'b0;
      bit_count <= '0;
    end else begin
      valid <= load_word;
      if (capture)   shift_reg <= shifted;
      if (load_word) word      <= word_src;
`ifdef SER_RX_PARITY_EN
      // bit_count reaches WIDTH while the parity bit is pending.
      if (capture)            bit_count <= bit_count + CW'(1);
      else if (state == PAR)  bit_count <= '0;
`else
      if (last_bit)           bit_count <= '0;
      else if (capture)       bit_count <= bit_count + CW'(1);
`endif
    end
  end

`ifdef SER_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= par_fail;
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: table-driven frames with a scoreboard,
// plus hand-written reset and parity sequences (parity part needs SER_RX_PARITY_EN).
`timescale 1ns/1ps
module tb_serial_word_receiver;

  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH+1);
`ifdef SER_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             din;
  logic [WIDTH-1:0] word;
  logic             valid;
  logic             busy;
  logic [CW-1:0]    bit_count;
  logic             perr;

  serial_word_receiver #(.WIDTH(WIDTH), .LSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .word(word), .valid(valid), .busy(busy), .bit_count(bit_count), .perr(perr)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic             err;
    int               cycle;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic             spurious;
    logic             gap;
    logic [WIDTH-1:0] exp_word;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Scoreboard consumer: every valid/perr pulse must match the oldest pending frame.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (valid || perr) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: valid=%0b perr=%0b word=%0h with no frame pending", valid, perr, word);
        end else begin
          e = sb.pop_front();
          checkOutput("valid", valid, !e.err);
          checkOutput("perr", perr, e.err);
          checkOutput("word", word, e.word);
          checkOutput("latency", cyc, e.cycle);
          checkOutput("busy_cycles", busy_run, WIDTH - 1 + PB);
        end
        busy_run = 0;
      end
      if (busy) busy_run++;
    end
  end

  task automatic drive_bit(input logic s, input logic d);
    start = s;
    din   = d;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] value, input logic spurious,
                               input logic bad_par, input logic [WIDTH-1:0] exp_word);
    exp_t e;
    e.word  = exp_word;
    e.err   = bad_par;
    e.cycle = cyc + WIDTH + PB;
    sb.push_back(e);
    for (int i = 0; i < WIDTH; i++)
      drive_bit((i == 0) || (spurious && (i == 5 || i == 20)), value[i]);
`ifdef SER_RX_PARITY_EN
    drive_bit(1'b0, (^value) ^ bad_par);
`endif
    start = 1'b0;
    din   = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    checkOutput({tag, "_word"}, word, 0);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_bit_count"}, bit_count, 0);
    checkOutput({tag, "_perr"}, perr, 0);
  endtask

  // Called on a falling edge; reset spans 4 ns in the middle of the low phase.
  task automatic pulseReset();
    #2 reset = 1'b1;
    #1 check_idle_zero("async_reset");
    #3 reset = 1'b0;
    sb.delete();
    busy_run = 0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (WIDTH + 5) @(negedge clk);
    checkOutput("drain_pending", sb.size(), 0);
  endtask

  initial begin
    vec_t vecs[6];
    logic [WIDTH-1:0] v;
    reset = 1'b1;
    start = 1'b0;
    din   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle_zero("reset");
    @(negedge clk);

    vecs[0] = '{32'd124,       1'b0, 1'b1, 32'h0000007C};
    vecs[1] = '{32'd123,       1'b0, 1'b0, 32'h0000007B};
    vecs[2] = '{32'd123,       1'b1, 1'b1, 32'h0000007B};
    vecs[3] = '{32'h00000000,  1'b0, 1'b0, 32'h00000000};
    vecs[4] = '{32'hFFFFFFFF,  1'b0, 1'b1, 32'hFFFFFFFF};
    vecs[5] = '{32'h80000001,  1'b0, 1'b0, 32'h80000001};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].gap) repeat (3) @(negedge clk);
      applyStimulus(vecs[i].value, vecs[i].spurious, 1'b0, vecs[i].exp_word);
    end
    drain();
    checkOutput("held_word", word, 32'h80000001);

    pulseReset();

    // Abort a frame after bit 10, then receive a clean one.
    v = 32'd123;
    for (int i = 0; i <= 10; i++) drive_bit(i == 0, v[i]);
    start = 1'b0;
    checkOutput("mid_bit_count", bit_count, 11);
    checkOutput("mid_busy", busy, 1);
    pulseReset();
    repeat (2) @(negedge clk);
    applyStimulus(32'd123, 1'b0, 1'b0, 32'h0000007B);
    drain();
    checkOutput("after_abort_word", word, 32'h0000007B);

`ifdef SER_RX_PARITY_EN
    applyStimulus(32'd124, 1'b0, 1'b0, 32'h0000007C);
    applyStimulus(32'd123, 1'b0, 1'b1, 32'h0000007C);
    drain();
    checkOutput("parity_hold_word", word, 32'h0000007C);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_receiver.md
# serial_word_receiver

Bit-serial to parallel word receiver: the receiving end of the team's bit-serial datapath, the counterpart of `shift_register`, which serialises a parallel word onto a 1-bit line. It samples one bit per clock after a start strobe, assembles a WIDTH-bit word, and presents it with a one-cycle valid pulse. It lets bit-serial units such as `sequential_unsigned_comparator` return or forward full words to parallel logic.

## Interface
- WIDTH, 32: word length in bits; legal range 2..64.
- LSB_FIRST, 1: 1 = first received bit lands in word[0]; 0 = first received bit lands in word[WIDTH-1].
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  frame start; din carries data bit 0 in the same cycle. Honoured only in IDLE.
- din  input  1  serial data bit, sampled every rising edge while receiving.
- word  output  WIDTH  last successfully received word; held until the next successful frame.
- valid  output  1  one-cycle pulse: word has just been updated.
- busy  output  1  high while a frame is in progress after its first bit.
- bit_count  output  $clog2(WIDTH+1)  bits captured so far in the current frame.
- perr  output  1  one-cycle parity-error pulse; constant 0 unless SER_RX_PARITY_EN is defined.

## Operation
- States:
  - IDLE: waiting for start.
  - RECV: capturing data bits.
  - PAR: capturing the parity bit. Exists only with SER_RX_PARITY_EN.
- Reset values: state IDLE; word, valid, busy, bit_count and perr all 0; internal shift register 0.
- IDLE with start=1: capture din, set bit_count=1, go to RECV. IDLE with start=0: no state change.
- RECV: capture din every edge and increment bit_count. start is ignored and treated as don't-care.
- Capture order:
  - LSB_FIRST=1: shift right with din entering at the MSB.
  - LSB_FIRST=0: shift left with din entering at the LSB.
- Frame end without parity: on the edge that captures bit WIDTH-1:
  - load word from {din, shift register} assembled in the correct order;
  - assert valid for one cycle;
  - set bit_count to 0 and return to IDLE.
- Frame end with parity: after bit WIDTH-1, go to PAR. On the PAR edge, compute XOR(data bits, din):
  - result 0 (even parity OK): update word and pulse valid;
  - result 1: pulse perr and leave word unchanged.
  - In both cases return to IDLE.
- Back-to-back frames: start may be asserted in the cycle that valid (or perr) is high, because the block is already in IDLE. No dead cycle is required.
- Reset mid-frame: the partial frame is discarded; valid and perr do not fire; word returns to 0.

## Timing
- Label the edge that samples start=1 as e0.
- Data bits are captured at e0..e(WIDTH-1).
- busy is high in the cycles following e0 through e(WIDTH-2). It is high for WIDTH-1 cycles, plus 1 extra cycle with parity.
- valid/perr is high in the cycle after e(WIDTH-1), or after eWIDTH with parity. Latency from start to valid is WIDTH cycles, or WIDTH+1 with parity.
- bit_count reads k in the cycle after edge e(k-1), and reads 0 in IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- SER_RX_PARITY_EN defined:
  - the frame is WIDTH data bits followed by one even-parity bit;
  - the PAR state exists;
  - perr is functional;
  - word is updated only on correct parity.
- SER_RX_PARITY_EN undefined:
  - the frame is WIDTH bits;
  - there is no PAR state;
  - perr is tied to 0;
  - every completed frame updates word.

## Test plan
- Reset: assert reset for 4 ns mid-cycle -> word=0, valid=0, busy=0, bit_count=0, perr=0 immediately, asynchronously.
- Single frame: start with 32'd124 sent LSB-first -> valid exactly 32 cycles after the start edge; word=32'h0000007C; busy high for 31 cycles.
- Back-to-back: 124 then 123, with the second start in the valid cycle -> two valid pulses 32 cycles apart; word=32'h7C, then 32'h7B.
- Spurious start: start pulses at bits 5 and 20 of frame 123 -> no restart; word=32'h7B; exactly one valid pulse.
- Reset mid-frame: reset after bit 10, then a full frame of 123 -> no valid for the aborted frame; word=32'h7B after the second frame.
- Parity (SER_RX_PARITY_EN, value 124 with 5 ones):
  - parity bit 1 -> valid at cycle 33 and word=32'h7C;
  - parity bit 0 -> perr at cycle 33, no valid, word holds its previous value.
